// File: rtl/bk_i2s_dac.sv
// bk_i2s_dac: mixes beeper/tape pulses and PCM into a 16-bit sample, streams it as I2S master
// to the codec, and slices the left ADC channel with hysteresis into tapein.
module bk_i2s_dac #(
  parameter logic [15:0] HYST   = 16'h0400,
  parameter logic [15:0] OFFSET = 16'h2800
) (
  input  logic       clk18,
  input  logic       reset_in,
  input  logic [3:0] pulses,
  input  logic [7:0] pcm,
  input  logic       iAUD_ADCDAT,
  output logic       oAUD_BCK,
  output logic       oAUD_LRCK,
  output logic       oAUD_ADCLRCK,
  output logic       oAUD_DATA,
  output logic       tapein
);
  logic [3:0]  r_pul1, r_pul2;
  logic [7:0]  r_pcm1, r_pcm2;
  logic        r_adc1, r_adc2;
  logic [2:0]  r_div;
  logic [5:0]  r_bit;
  logic [15:0] r_sample, r_adc_sr;
  logic        r_bck, r_lrck, r_data, r_tapein;
  logic        w_fall, w_rise, w_cap, w_eval, w_data_n;
  logic [5:0]  w_bit_n;
  logic [4:0]  w_idx;
  logic [2:0]  w_cnt;
  logic [15:0] w_u, w_mix, w_neg_hyst;
  assign w_fall     = r_div == 3'd5;
  assign w_rise     = r_div == 3'd2;
  assign w_bit_n    = r_bit + 6'd1;
  assign w_idx      = 5'd16 - w_bit_n[4:0];
  assign w_data_n   = (w_bit_n[4:0] != 5'd0 && w_bit_n[4:0] <= 5'd16) ? r_sample[w_idx[3:0]] : 1'b0;
  assign w_cap      = !r_bit[5] && r_bit[4:0] >= 5'd1 && r_bit[4:0] <= 5'd16;
  // tapein is decided one clock after the slot-16 rising edge, once the full word sits in adc_sr
  assign w_eval     = r_div == 3'd3 && !r_bit[5] && r_bit[4:0] == 5'd16;
  assign w_cnt      = 3'(r_pul2[0]) + 3'(r_pul2[1]) + 3'(r_pul2[2]) + 3'(r_pul2[3]);
  assign w_u        = {1'b0, w_cnt, 12'h000} + {4'h0, r_pcm2, 4'h0};
  assign w_mix      = w_u - OFFSET;
  assign w_neg_hyst = 16'h0000 - HYST;
  always_ff @(posedge clk18 or posedge reset_in) begin
    if (reset_in) begin
      r_pul1   <= '0;
      r_pul2   <= '0;
      r_pcm1   <= '0;
      r_pcm2   <= '0;
      r_adc1   <= 1'b0;
      r_adc2   <= 1'b0;
      r_div    <= '0;
      r_bit    <= 6'd63;
      r_sample <= '0;
      r_adc_sr <= '0;
      r_bck    <= 1'b0;
      r_lrck   <= 1'b0;
      r_data   <= 1'b0;
      r_tapein <= 1'b0;
    end else begin
      r_pul1 <= pulses;
      r_pul2 <= r_pul1;
      r_pcm1 <= pcm;
      r_pcm2 <= r_pcm1;
      r_adc1 <= iAUD_ADCDAT;
      r_adc2 <= r_adc1;
      r_div  <= w_fall ? 3'd0 : r_div + 3'd1;
      r_bck  <= w_rise ? 1'b1 : w_fall ? 1'b0 : r_bck;
      if (w_fall) begin
        r_bit  <= w_bit_n;
        r_lrck <= w_bit_n[5];
        r_data <= w_data_n;
        if (w_bit_n == 6'd0) r_sample <= w_mix;
      end
      if (w_rise && w_cap) r_adc_sr <= {r_adc_sr[14:0], r_adc2};
      if (w_eval) r_tapein <= $signed(r_adc_sr) > $signed(HYST) ? 1'b1 :
                              $signed(r_adc_sr) < $signed(w_neg_hyst) ? 1'b0 : r_tapein;
    end
  end
  assign oAUD_BCK     = r_bck;
  assign oAUD_LRCK    = r_lrck;
  assign oAUD_ADCLRCK = r_lrck;
  assign oAUD_DATA    = r_data;
  assign tapein       = r_tapein;
endmodule

// File: tb/tb_bk_i2s_dac.sv
// tb_bk_i2s_dac: drives directed mixes and ADC words through bk_i2s_dac, checking every cycle
// against a frame-level model plus literal per-frame word and tapein expectations.
module tb_bk_i2s_dac;
  logic       clk18 = 1'b0;
  logic       reset_in = 1'b0;
  logic [3:0] pulses = 4'b0001;
  logic [7:0] pcm = 8'h00;
  logic       iAUD_ADCDAT = 1'b0;
  logic       oAUD_BCK, oAUD_LRCK, oAUD_ADCLRCK, oAUD_DATA, tapein;
  logic [15:0] adc_left = 16'h0500;
  logic [15:0] adc_right = 16'h7FFF;
  logic [15:0] cap_l = '0, cap_r = '0, shift_w = '0, m_sample = '0;
  logic        m_tap = 1'b0;
  int          k = 0;
  int          n_cmp = 0, n_err = 0;
  int          cs = 31;
  logic        cl = 1'b0;

  bk_i2s_dac dut (
    .clk18(clk18), .reset_in(reset_in), .pulses(pulses), .pcm(pcm),
    .iAUD_ADCDAT(iAUD_ADCDAT), .oAUD_BCK(oAUD_BCK), .oAUD_LRCK(oAUD_LRCK),
    .oAUD_ADCLRCK(oAUD_ADCLRCK), .oAUD_DATA(oAUD_DATA), .tapein(tapein)
  );

  always #5 clk18 = ~clk18;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mix(input logic [3:0] p, input logic [7:0] c);
    int v;
    v = $countones(p) * 4096 + int'(c) * 16 - 'h2800;
    return v[15:0];
  endfunction

  // posedges since reset release; the whole model is derived from this count
  always @(posedge clk18 or posedge reset_in)
    if (reset_in) k <= 0;
    else k <= k + 1;

  // codec ADC side: shifts its words out MSB first after each BCK fall, slot 1 onwards
  always @(negedge oAUD_BCK or posedge reset_in) begin
    if (reset_in) begin
      cs = 31;
      cl = 1'b0;
      iAUD_ADCDAT = 1'b0;
    end else begin
      cs = (oAUD_LRCK != cl) ? 0 : (cs + 1) % 32;
      cl = oAUD_LRCK;
      iAUD_ADCDAT = (cs >= 1 && cs <= 16) ? (cl ? adc_right[16-cs] : adc_left[16-cs]) : 1'b1;
    end
  end

  always @(negedge clk18) begin
    int c, d, b, s, w;
    logic e_l, e_d;
    if (reset_in) begin
      m_tap = 1'b0;
      chk("rst_bck", 16'(oAUD_BCK), 16'd0);
      chk("rst_lrck", 16'(oAUD_LRCK), 16'd0);
      chk("rst_adclrck", 16'(oAUD_ADCLRCK), 16'd0);
      chk("rst_data", 16'(oAUD_DATA), 16'd0);
      chk("rst_tapein", 16'(tapein), 16'd0);
    end else begin
      c = k / 6;
      d = k % 6;
      b = (63 + c) % 64;
      s = b % 32;
      if (c >= 1 && d == 0 && b == 0) m_sample = mix(pulses, pcm);
      if (c >= 1 && d == 4 && b == 16) begin
        w = int'($signed(adc_left));
        m_tap = w > 1024 ? 1'b1 : w < -1024 ? 1'b0 : m_tap;
      end
      e_l = c >= 1 && b >= 32;
      e_d = (c >= 1 && s >= 1 && s <= 16) ? m_sample[16-s] : 1'b0;
      chk("bck", 16'(oAUD_BCK), 16'(d >= 3));
      chk("lrck", 16'(oAUD_LRCK), 16'(e_l));
      chk("adclrck", 16'(oAUD_ADCLRCK), 16'(e_l));
      chk("data", 16'(oAUD_DATA), 16'(e_d));
      chk("tapein", 16'(tapein), 16'(m_tap));
      if (c >= 1 && d == 0 && s >= 1 && s <= 16) begin
        shift_w = {shift_w[14:0], oAUD_DATA};
        if (s == 16) begin
          if (b >= 32) cap_r = shift_w;
          else cap_l = shift_w;
        end
      end
    end
  end

  task automatic wait_lrck(input logic v);
    int i;
    logic p;
    p = oAUD_LRCK;
    for (i = 0; i < 500; i++) begin
      @(negedge clk18);
      if (oAUD_LRCK == v && p != v) break;
      p = oAUD_LRCK;
    end
    chk("lrck_edge_timeout", 16'(i < 500), 16'd1);
  endtask

  // sets the next frame's inputs mid-frame, then checks the frame just finished
  task automatic step(input logic [3:0] p, input logic [7:0] c, input logic [15:0] a,
                      input logic [15:0] wd, input logic t);
    wait_lrck(1'b1);
    pulses = p;
    pcm = c;
    adc_left = a;
    wait_lrck(1'b0);
    chk("word_left", cap_l, wd);
    chk("word_right", cap_r, wd);
    chk("tapein_frame", 16'(tapein), 16'(t));
  endtask

  initial begin
    int falls, toggles;
    logic pb, pl;
    #1 reset_in = 1'b1;
    repeat (3) @(posedge clk18);
    #2 reset_in = 1'b0;
    step(4'h0, 8'h00, 16'h0100, 16'hE800, 1'b1);
    step(4'hF, 8'hFF, 16'hFC00, 16'hD800, 1'b1);
    step(4'h0, 8'h00, 16'hFB00, 16'h27F0, 1'b1);
    step(4'h0, 8'h80, 16'h0000, 16'hD800, 1'b0);
    step(4'h0, 8'h80, 16'h0500, 16'hE000, 1'b0);
    falls = 0;
    toggles = 0;
    pb = oAUD_BCK;
    pl = oAUD_LRCK;
    for (int i = 0; i < 1152; i++) begin
      @(negedge clk18);
      if (pb && !oAUD_BCK) falls++;
      if (pl != oAUD_LRCK) toggles++;
      pb = oAUD_BCK;
      pl = oAUD_LRCK;
    end
    chk("bck_falls_3frames", 16'(falls), 16'd192);
    chk("lrck_toggles_3frames", 16'(toggles), 16'd6);
    chk("tapein_before_reset", 16'(tapein), 16'd1);
    wait_lrck(1'b1);
    repeat (20) @(posedge clk18);
    #2 reset_in = 1'b1;
    #1;
    chk("midreset_bck", 16'(oAUD_BCK), 16'd0);
    chk("midreset_lrck", 16'(oAUD_LRCK), 16'd0);
    chk("midreset_adclrck", 16'(oAUD_ADCLRCK), 16'd0);
    chk("midreset_data", 16'(oAUD_DATA), 16'd0);
    chk("midreset_tapein", 16'(tapein), 16'd0);
    pulses = 4'b0011;
    pcm = 8'h00;
    repeat (4) @(posedge clk18);
    #2 reset_in = 1'b0;
    step(4'b0011, 8'h00, 16'h0500, 16'hF800, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bk_i2s_dac.md
# bk_i2s_dac

Audio codec serial stage downstream of the BK core's sound sources. Mixes the tape/beeper pulse lines and the 8-bit PCM (AY) level into one 16-bit signed sample. Streams that sample to the DE1 WM8731 codec as I2S master (BCK, LRCK, DATA). Also receives the codec ADC stream and slices the left channel with hysteresis into the `tapein` bit fed back to the core.

## Interface

Parameters:
- `HYST`, 16'h0400: hysteresis threshold magnitude for the tape-in slicer, signed compare.
- `OFFSET`, 16'h2800: DC offset subtracted from the unsigned mix.

Ports:
- `clk18`, in, 1: audio clock, 18.432 MHz (the PLL `aud_clk`).
- `reset_in`, in, 1: reset, asynchronous, active-high.
- `pulses`, in, 4: one-bit sound sources (tape_out on bit 3); asynchronous to `clk18`.
- `pcm`, in, 8: unsigned PCM level; quasi-static, asynchronous to `clk18`.
- `iAUD_ADCDAT`, in, 1: codec ADC serial data.
- `oAUD_BCK`, out, 1: bit clock, `clk18`/6 = 3.072 MHz.
- `oAUD_LRCK`, out, 1: DAC word select; 0 = left, 1 = right; 48 kHz.
- `oAUD_ADCLRCK`, out, 1: ADC word select, identical to `oAUD_LRCK`.
- `oAUD_DATA`, out, 1: DAC serial data.
- `tapein`, out, 1: sliced tape input level.

## Operation

**Input synchronisation**
- `pulses` and `iAUD_ADCDAT` pass through 2-flop synchronisers.
- `pcm` is registered twice. Tearing on a changing `pcm` is accepted.

**Bit-clock divider**
- `div` counts 0..5 and wraps.
- `oAUD_BCK` is 0 for `div` 0..2 and 1 for `div` 3..5.
- The BCK falling edge is the clock where `div` goes 5->0.

**Bit counter**
- `bit` is 6 bits, 0..63, and increments on each BCK falling edge.
- It wraps 63->0, giving a frame of 64 BCK = 384 `clk18` cycles.
- `oAUD_LRCK` = `bit[5]`, registered.

**Mix**
- Computed at the frame boundary (`bit` 63->0).
- n = popcount of the synchronised `pulses` (0..4).
- u = (n << 12) + (pcm << 4), 16-bit unsigned, range 0..0x4FF0.
- sample = u − OFFSET, 16-bit two's complement, range 0xD800..0x27F0. No overflow is possible.
- `sample` is latched and held for the whole frame. Both channels carry the same sample.

**DAC serialisation (I2S, left-justified one BCK late)**
- Let slot = `bit[4:0]`.
- Slot 0: DATA = 0.
- Slots 1..16: DATA = sample[16−slot], i.e. MSB first.
- Slots 17..31: DATA = 0.
- DATA changes only on BCK falling edges.

**ADC capture**
- Captured on BCK rising edges (`div` 2->3) while `bit[5]` = 0 and slot is 1..16.
- Shifted MSB-first into `adc_sr[15:0]`.
- On the rising edge of slot 16, the full word w is evaluated:
  - if w > +HYST (signed): `tapein` <= 1;
  - else if w < −HYST: `tapein` <= 0;
  - otherwise `tapein` holds.
- The right-channel ADC data is ignored.

## Timing

**Reset values**
- `div` = 0, `bit` = 63, `sample` = 0.
- `adc_sr` = 0 and all synchroniser flops = 0.
- Outputs: `oAUD_BCK` = 0, `oAUD_LRCK` = 0, `oAUD_ADCLRCK` = 0, `oAUD_DATA` = 0, `tapein` = 0.

**After reset release**
- The first BCK falling edge comes 6 clocks after release. It is a frame boundary: `bit` -> 0 and the first sample is latched.

**Latency**
- Input to serial output: a `pulses`/`pcm` change reaches `sample` 2 sync clocks plus up to 384 clocks later.
- The MSB appears on `oAUD_DATA` 6 clocks after the LRCK falling edge.
- Input to `tapein`: `tapein` updates 1 clock after the slot-16 BCK rising edge of the left channel, once per frame.

**Reset mid-frame**
- All state returns to reset values immediately (asynchronously).
- No partial word is evaluated for `tapein`.

**Simultaneous events**
- The frame-boundary sample latch and DATA = 0 for slot 0 happen on the same clock. The new sample first affects slot 1.
- LRCK and ADCLRCK change on the same clock as DATA.

## Test plan

- **Reset:** assert `reset_in` mid-frame -> all outputs 0 within the same cycle. After release: BCK period 6 clocks, LRCK period 384 clocks, duty 50%.
- **Mix value 0xE800:** `pulses`=4'b0001, `pcm`=0 -> slots 1..16 of both channels carry 0xE800. Slots 0 and 17..31 are 0.
- **Mix extremes:** `pulses`=4'b0000, `pcm`=0 -> 0xD800. `pulses`=4'b1111, `pcm`=8'hFF -> 0x27F0.
- **Input change mid-frame:** change `pcm` from 0x00 to 0x80 with `pulses`=0 in the middle of a frame -> the current frame still sends 0xD800, the next frame sends 0xE000.
- **Tape-in hysteresis:** ADC left words 0x0500, 0x0100, 0xFC00, 0xFB00 on consecutive frames -> `tapein` = 1, 1, 1, 0. Right-channel data of 0x7FFF has no effect.
- **Divider and bit-counter wrap:** run 3 full frames -> exactly 192 BCK falling edges, and LRCK toggles on `bit` 31->32 and 63->0 only.
